// File: rtl/tft_timing_gen_if.sv
// Pixel-source and panel-pin bundle for the TFT timing generator.
// master = the generator (drives requests and pins, receives source data);
// slave  = the consumer side (pixel source + panel), used by benches/wrappers.
interface tft_timing_gen_if #(
    parameter int HN = 9,
    parameter int VN = 9
);
    logic          req;
    logic [HN-1:0] x;
    logic [VN-1:0] y;
    logic [23:0]   data;
    logic [23:0]   out;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic          disp;
    logic          dclk;
    logic          frame_start;
    logic [7:0]    frame;

    modport master (
        output req, x, y, out, de, hsync, vsync, disp, dclk, frame_start, frame,
        input  data
    );

    modport slave (
        input  req, x, y, out, de, hsync, vsync, disp, dclk, frame_start, frame,
        output data
    );
endinterface

// File: rtl/tft_timing_gen.sv
// RGB TFT timing generator: porch-parameterised H/V sync, DE, pixel requests and RGB pipeline.
// Latency: req/x/y lead the panel pins by LEAD+1 clocks; source data is due LEAD clocks after req.
// No backpressure: free-running pixel clock; en=0 parks the counters and blanks the pins.
// Ports: clk, reset (sync, active high), en; bus (master) carries req/x/y/data to the pixel
// source and out/de/hsync/vsync/disp/dclk/frame_start/frame to the panel.
module tft_timing_gen #(
    parameter int HN       = 9,
    parameter int VN       = 9,
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 1,
    parameter int H_ACT    = 480,
    parameter int H_FRONT  = 1,
    parameter int V_SYNC   = 10,
    parameter int V_BACK   = 1,
    parameter int V_ACT    = 272,
    parameter int V_FRONT  = 1,
    parameter int SYNC_POL = 0,
    parameter int DE_POL   = 1,
    parameter int LEAD     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    tft_timing_gen_if.master bus
);

    typedef enum logic [1:0] {
        PH_SYNC  = 2'd0,
        PH_BACK  = 2'd1,
        PH_ACT   = 2'd2,
        PH_FRONT = 2'd3
    } phase_t;

    // Active-high timing flags; polarity is applied only at the pins.
    typedef struct packed {
        logic fs;
        logic de;
        logic vs;
        logic hs;
    } tim_t;

    localparam logic SP = (SYNC_POL != 0);
    localparam logic DP = (DE_POL != 0);

    phase_t        h_state, h_state_nxt;
    phase_t        v_state, v_state_nxt;
    logic [HN-1:0] h_cnt, h_cnt_nxt, h_end;
    logic [VN-1:0] v_cnt, v_cnt_nxt, v_end;

    tim_t          cd;        // flags of the position held in the counters
    tim_t          cd_q;      // counter-domain cycle: aligned with req/x/y
    tim_t          pre;       // stage that reaches the pins on the next edge
    tim_t [LEAD:0] dly;       // dly[LEAD] drives the pins

    logic [HN-1:0] x_q;
    logic [VN-1:0] y_q;
    logic [23:0]   out_q;
    logic          disp_q;
    logic [7:0]    frame_q;

    function automatic phase_t phase_next(input phase_t p);
        case (p)
            PH_SYNC: return PH_BACK;
            PH_BACK: return PH_ACT;
            PH_ACT:  return PH_FRONT;
            default: return PH_SYNC;
        endcase
    endfunction

    // Next-state: the phase counter reloads on every phase change; the vertical
    // FSM steps once per line at the HFRONT->HSYNC wrap. en=0 parks both at sync/0.
    always_comb begin
        h_end       = HN'(H_FRONT - 1);
        v_end       = VN'(V_FRONT - 1);
        h_state_nxt = h_state;
        h_cnt_nxt   = h_cnt + 1'b1;
        v_state_nxt = v_state;
        v_cnt_nxt   = v_cnt;
        cd          = '0;

        case (h_state)
            PH_SYNC: h_end = HN'(H_SYNC - 1);
            PH_BACK: h_end = HN'(H_BACK - 1);
            PH_ACT:  h_end = HN'(H_ACT - 1);
            default: h_end = HN'(H_FRONT - 1);
        endcase

        case (v_state)
            PH_SYNC: v_end = VN'(V_SYNC - 1);
            PH_BACK: v_end = VN'(V_BACK - 1);
            PH_ACT:  v_end = VN'(V_ACT - 1);
            default: v_end = VN'(V_FRONT - 1);
        endcase

        if (h_cnt == h_end) begin
            h_cnt_nxt   = '0;
            h_state_nxt = phase_next(h_state);
            if (h_state == PH_FRONT) begin
                v_cnt_nxt = v_cnt + 1'b1;
                if (v_cnt == v_end) begin
                    v_cnt_nxt   = '0;
                    v_state_nxt = phase_next(v_state);
                end
            end
        end

        if (!en) begin
            h_state_nxt = PH_SYNC;
            h_cnt_nxt   = '0;
            v_state_nxt = PH_SYNC;
            v_cnt_nxt   = '0;
        end else begin
            cd.hs = (h_state == PH_SYNC);
            cd.vs = (v_state == PH_SYNC);
            cd.de = (h_state == PH_ACT) && (v_state == PH_ACT);
            cd.fs = (h_state == PH_SYNC) && (h_cnt == '0) &&
                    (v_state == PH_SYNC) && (v_cnt == '0);
        end
    end

    // The output register samples data at the end of cycle c+LEAD, i.e. while
    // the matching flags sit one stage short of the pins.
    generate
        if (LEAD == 0) begin : g_pre_direct
            assign pre = cd_q;
        end else begin : g_pre_delayed
            assign pre = dly[LEAD-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            h_state <= PH_SYNC;
            h_cnt   <= '0;
            v_state <= PH_SYNC;
            v_cnt   <= '0;
            cd_q    <= '0;
            dly     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            out_q   <= '0;
            disp_q  <= 1'b0;
            frame_q <= '0;
        end else begin
            h_state <= h_state_nxt;
            h_cnt   <= h_cnt_nxt;
            v_state <= v_state_nxt;
            v_cnt   <= v_cnt_nxt;
            cd_q    <= cd;
            x_q     <= cd.de ? h_cnt : '0;
            y_q     <= cd.de ? v_cnt : '0;
            dly[0]  <= cd_q;
            for (int i = 1; i <= LEAD; i++) begin
                dly[i] <= dly[i-1];
            end
            out_q   <= pre.de ? bus.data : '0;
            disp_q  <= en;
            frame_q <= frame_q + {7'd0, pre.fs};
        end
    end

    assign bus.req         = cd_q.de;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.out         = out_q;
    assign bus.de          = dly[LEAD].de ? DP : ~DP;
    assign bus.hsync       = dly[LEAD].hs ? SP : ~SP;
    assign bus.vsync       = dly[LEAD].vs ? SP : ~SP;
    assign bus.frame_start = dly[LEAD].fs;
    assign bus.frame       = frame_q;
    assign bus.disp        = disp_q;
    assign bus.dclk        = ~clk;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen: two instances (normal and inverted polarity) share stimulus.
// A frame-position model pushes expected pin/request records into queues on each clock;
// a monitor pops and compares them half a cycle later. A source model echoes {x,y} as data.
`timescale 1ns/1ps
module tb_tft_timing_gen;
    localparam int HN = 8, VN = 8, LEAD = 2;
    localparam int HS = 2, HB = 3, HA = 8, HF = 2;
    localparam int VS = 1, VB = 2, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;

    typedef struct {
        bit          hs, vs, de, fs, clr;
        logic [23:0] pix;
    } pin_t;

    typedef struct {
        bit         req, disp;
        logic [7:0] x, y;
    } cd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [23:0] src_data = '0;

    int          errors = 0;
    int          checks = 0;
    bit          started = 0;
    int          pos = 0;
    logic [7:0]  frame_exp = '0;
    pin_t        pin_q[$];
    cd_t         cd_q[$];
    logic [23:0] src_q[$];

    always #5 clk = ~clk;

    tft_timing_gen_if #(.HN(HN), .VN(VN)) bus_a ();
    tft_timing_gen_if #(.HN(HN), .VN(VN)) bus_b ();
    assign bus_a.data = src_data;
    assign bus_b.data = src_data;

    tft_timing_gen #(
        .HN(HN), .VN(VN), .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
        .SYNC_POL(0), .DE_POL(1), .LEAD(LEAD)
    ) dut_a (.clk(clk), .reset(reset), .en(en), .bus(bus_a));

    tft_timing_gen #(
        .HN(HN), .VN(VN), .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
        .SYNC_POL(1), .DE_POL(0), .LEAD(LEAD)
    ) dut_b (.clk(clk), .reset(reset), .en(en), .bus(bus_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // Position p counts clocks from the start of a frame; line and column follow by division.
    function automatic pin_t pin_of(input int p);
        pin_t r;
        int h, l;
        bit hact, vact;
        h = p % HT;
        l = p / HT;
        hact = (h >= HS + HB) && (h < HS + HB + HA);
        vact = (l >= VS + VB) && (l < VS + VB + VA);
        r.hs  = (h < HS);
        r.vs  = (l < VS);
        r.de  = hact && vact;
        r.fs  = (p == 0);
        r.clr = 0;
        r.pix = r.de ? {8'h00, 8'(h - HS - HB), 8'(l - VS - VB)} : 24'h0;
        return r;
    endfunction

    function automatic pin_t pin_idle(input bit clr);
        pin_t r;
        r.hs = 0; r.vs = 0; r.de = 0; r.fs = 0; r.clr = clr; r.pix = '0;
        return r;
    endfunction

    // Reference model: runs on each rising edge using the inputs that edge samples.
    initial begin
        pin_t p;
        cd_t  c;
        forever begin
            @(posedge clk);
            if (reset) begin
                started = 1;
                pos = 0;
                pin_q.delete();
                cd_q.delete();
                for (int i = 0; i < LEAD + 2; i++) pin_q.push_back(pin_idle(i == 0));
                c.req = 0; c.disp = 0; c.x = '0; c.y = '0;
                cd_q.push_back(c);
            end else if (started) begin
                if (en) begin
                    p = pin_of(pos);
                    pos = (pos + 1) % FT;
                end else begin
                    p = pin_idle(0);
                    pos = 0;
                end
                c.req  = p.de;
                c.disp = en;
                c.x    = p.pix[15:8];
                c.y    = p.pix[7:0];
                pin_q.push_back(p);
                cd_q.push_back(c);
            end
        end
    end

    // Fixed-latency pixel source: answers each request LEAD clocks later; junk otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_a.req === 1'b1) src_q.push_back({8'h00, bus_a.x, bus_a.y});
            else                    src_q.push_back(24'($urandom));
            if (src_q.size() > LEAD) src_data = src_q.pop_front();
        end
    end

    // Monitor: one expected record per clock once the model has seen reset.
    initial begin
        pin_t p;
        cd_t  c;
        forever begin
            @(negedge clk);
            #1;
            if (started) begin
                if (pin_q.size() == 0 || cd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL queue_underflow t=%0t got=empty want=record", $time);
                end else begin
                    p = pin_q.pop_front();
                    c = cd_q.pop_front();
                    if (p.clr) frame_exp = '0;
                    if (p.fs)  frame_exp = frame_exp + 8'd1;
                    chk("req",     32'(bus_a.req),  32'(c.req));
                    if (c.req) begin
                        chk("x",   32'(bus_a.x),    32'(c.x));
                        chk("y",   32'(bus_a.y),    32'(c.y));
                    end
                    chk("disp",    32'(bus_a.disp), 32'(c.disp));
                    chk("dclk",    32'(bus_a.dclk), 32'd1);
                    chk("hsync_a", 32'(bus_a.hsync), 32'(!p.hs));
                    chk("vsync_a", 32'(bus_a.vsync), 32'(!p.vs));
                    chk("de_a",    32'(bus_a.de),    32'(p.de));
                    chk("fs_a",    32'(bus_a.frame_start), 32'(p.fs));
                    chk("frame_a", 32'(bus_a.frame), 32'(frame_exp));
                    chk("out_a",   32'(bus_a.out),   32'(p.pix));
                    chk("hsync_b", 32'(bus_b.hsync), 32'(p.hs));
                    chk("vsync_b", 32'(bus_b.vsync), 32'(p.vs));
                    chk("de_b",    32'(bus_b.de),    32'(!p.de));
                    chk("fs_b",    32'(bus_b.frame_start), 32'(p.fs));
                    chk("frame_b", 32'(bus_b.frame), 32'(frame_exp));
                    chk("out_b",   32'(bus_b.out),   32'(p.pix));
                end
            end
        end
    end

    task automatic wait_pixel(input int wx, input int wy);
        int n = 0;
        while (!(bus_a.req === 1'b1 && bus_a.x == 8'(wx) && bus_a.y == 8'(wy)) && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2 * FT) begin
            errors++;
            $display("FAIL wait_pixel t=%0t got=timeout want=req at x=%0d y=%0d", $time, wx, wy);
        end
    endtask

    // Stimulus: all input changes happen on the falling edge.
    initial begin
        reset = 1'b1;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (2 * FT + 7) @(negedge clk);

        // Reset in the middle of an active line, en left high through it.
        wait_pixel(3, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (FT + 11) @(negedge clk);

        // en dropped mid-frame for 20 clocks.
        wait_pixel(5, 1);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        repeat (FT + 3) @(negedge clk);

        // Random enable gaps.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(5, 200)) @(negedge clk);
            en = 1'b0;
            repeat ($urandom_range(1, 30)) @(negedge clk);
            en = 1'b1;
        end

        // Long run so the frame counter wraps.
        repeat (257 * FT + 10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
